// File: rtl/sys_array_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary systolic array: loads and latches
// weights, streams N skewed activation vectors, then drains results into the output buffer.
module sys_array_ctrl #(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int CNT_W = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic [CNT_W-1:0]                           num_vec,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       w_rd_en,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] w_rd_addr,
  output logic                                       w_shift,
  output logic [ROWS-1:0]                            weight_wren,
  output logic [ROWS-1:0]                            row_active,
  output logic [CNT_W-1:0]                           vec_idx,
  output logic                                       out_wr_en,
  output logic [CNT_W-1:0]                           out_addr
);

  localparam int AW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LAT = ROWS + COLS;
  localparam int SW  = CNT_W + $clog2(ROWS + COLS) + 1;
  localparam logic [SW-1:0] ONE = SW'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LATCH_W,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;

  logic [SW-1:0] n_ext;
  logic [SW-1:0] stream_last;
  logic [SW-1:0] drain_last;

  // cnt_q is the row index during LOAD_W and the stream-relative s from STREAM onward
  assign n_ext       = {{(SW-CNT_W){1'b0}}, n_q};
  assign stream_last = n_ext + SW'(ROWS - 1) - ONE;
  assign drain_last  = n_ext + SW'(LAT) - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD_W;
          n_d     = num_vec;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (cnt_q == SW'(ROWS - 1)) begin
          state_d = LATCH_W;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LATCH_W: begin
        cnt_d = '0;
        if (n_q == '0) state_d = DONE;
        else           state_d = STREAM;
      end
      STREAM: begin
        // s keeps counting into DRAIN so result timing stays relative to the first stream cycle
        cnt_d = cnt_q + ONE;
        if (cnt_q == stream_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == drain_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      n_d     = '0;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE) && (state_q != DONE);
    done        = (state_q == DONE);
    w_rd_en     = 1'b0;
    w_shift     = 1'b0;
    w_rd_addr   = '0;
    weight_wren = '0;
    row_active  = '0;
    vec_idx     = '0;
    out_wr_en   = 1'b0;
    out_addr    = '0;
    if (state_q == LOAD_W) begin
      w_rd_en   = 1'b1;
      w_shift   = 1'b1;
      w_rd_addr = AW'(ROWS - 1) - AW'(cnt_q);
    end
    if (state_q == LATCH_W) weight_wren = '1;
    if (state_q == STREAM) begin
      // row r sees vector k at s = r + k, giving the diagonal wavefront
      for (int r = 0; r < ROWS; r++) begin
        row_active[r] = (cnt_q >= SW'(r)) && (cnt_q < n_ext + SW'(r));
      end
      if (cnt_q < n_ext) vec_idx = CNT_W'(cnt_q);
    end
    if ((state_q == STREAM) || (state_q == DRAIN)) begin
      if ((cnt_q >= SW'(LAT)) && (cnt_q < n_ext + SW'(LAT))) begin
        out_wr_en = 1'b1;
        out_addr  = CNT_W'(cnt_q - SW'(LAT));
      end
    end
  end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Scoreboard bench for sys_array_ctrl: jobs push expected strobe events (cycle, value)
// into queues; a negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_sys_array_ctrl;

  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int CNT_W = 8;
  localparam int LAT   = ROWS + COLS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             busy, done, w_rd_en, w_shift, out_wr_en;
  logic [0:0]       w_rd_addr;
  logic [ROWS-1:0]  weight_wren, row_active;
  logic [CNT_W-1:0] vec_idx, out_addr;
  logic [25:0]      all_out;

  sys_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .w_shift(w_shift), .weight_wren(weight_wren), .row_active(row_active),
    .vec_idx(vec_idx), .out_wr_en(out_wr_en), .out_addr(out_addr)
  );

  assign all_out = {busy, done, w_rd_en, w_rd_addr, w_shift, weight_wren,
                    row_active, vec_idx, out_wr_en, out_addr};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t q_ld[$], q_lt[$], q_row[$], q_out[$], q_dn[$];
  int n_chk = 0, n_err = 0;
  int n_out = 0, n_done = 0, last_addr = -1, last_done_cyc = -1;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_ev(input string nm, input ev_t e, input int act_val);
    n_chk++;
    if ((cyc != e.cyc) || (act_val != e.val)) begin
      n_err++;
      $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d",
               nm, cyc, act_val, e.cyc, e.val);
    end
  endtask

  task automatic unexpected(input string nm, input int act_val);
    n_chk++;
    n_err++;
    $display("FAIL %s: unexpected strobe at cycle %0d value %0d, expected none", nm, cyc, act_val);
  endtask

  function automatic ev_t mk(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  // Expected events of one job started (start high) in cycle c0; events after relative cycle cut are dropped
  task automatic push_job(input int c0, input int n, input int cut);
    int ra, vi, rel;
    for (int i = 0; i < ROWS; i++)
      if (1 + i <= cut) q_ld.push_back(mk(c0 + 1 + i, ROWS - 1 - i));
    if (ROWS + 1 <= cut) q_lt.push_back(mk(c0 + ROWS + 1, (1 << ROWS) - 1));
    if (n == 0) begin
      if (ROWS + 2 <= cut) q_dn.push_back(mk(c0 + ROWS + 2, 0));
      return;
    end
    for (int s = 0; s < n + ROWS - 1; s++) begin
      ra = 0;
      for (int r = 0; r < ROWS; r++)
        if ((s >= r) && (s < r + n)) ra |= (1 << r);
      vi  = (s < n) ? s : 0;
      rel = ROWS + 2 + s;
      if ((ra != 0) && (rel <= cut)) q_row.push_back(mk(c0 + rel, vi * 256 + ra));
    end
    for (int k = 0; k < n; k++) begin
      rel = ROWS + 2 + LAT + k;
      if (rel <= cut) q_out.push_back(mk(c0 + rel, k));
    end
    rel = ROWS + 2 + LAT + n;
    if (rel <= cut) q_dn.push_back(mk(c0 + rel, 0));
  endtask

  task automatic check_empty(input string p);
    check({p, "_q_load"},  q_ld.size(),  0);
    check({p, "_q_latch"}, q_lt.size(),  0);
    check({p, "_q_row"},   q_row.size(), 0);
    check({p, "_q_out"},   q_out.size(), 0);
    check({p, "_q_done"},  q_dn.size(),  0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (w_rd_en) begin
        check("load_busy_shift", int'({busy, w_shift}), 3);
        if (q_ld.size() > 0) begin
          e = q_ld.pop_front();
          check_ev("load", e, int'(w_rd_addr));
        end else unexpected("load", int'(w_rd_addr));
      end else if (w_shift) unexpected("shift", 1);
      if (weight_wren != '0) begin
        if (q_lt.size() > 0) begin
          e = q_lt.pop_front();
          check_ev("latch", e, int'(weight_wren));
        end else unexpected("latch", int'(weight_wren));
      end
      if ((row_active != '0) || (vec_idx != '0)) begin
        if (q_row.size() > 0) begin
          e = q_row.pop_front();
          check_ev("row", e, int'(vec_idx) * 256 + int'(row_active));
        end else unexpected("row", int'(vec_idx) * 256 + int'(row_active));
      end
      if (out_wr_en) begin
        n_out++;
        last_addr = int'(out_addr);
        if (q_out.size() > 0) begin
          e = q_out.pop_front();
          check_ev("out", e, int'(out_addr));
        end else unexpected("out", int'(out_addr));
      end
      if (done) begin
        n_done++;
        last_done_cyc = cyc;
        check("done_busy", int'(busy), 0);
        if (q_dn.size() > 0) begin
          e = q_dn.pop_front();
          check_ev("done", e, 0);
        end else unexpected("done", 0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Reset state
    #2;
    check("rst_outs", int'(all_out), 0);
    check("rst_busy", int'(busy), 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic job, N=3
    c0 = cyc; n_out = 0; n_done = 0;
    num_vec = 8'd3; start = 1'b1;
    push_job(c0, 3, 1000);
    @(posedge clk); #1; start = 1'b0;
    wait_until(c0 + 14);
    check("A_done_cycle", last_done_cyc - c0, 11);
    check("A_n_out", n_out, 3);
    check("A_last_addr", last_addr, 2);
    check("A_n_done", n_done, 1);
    check_empty("A");

    // Empty job, N=0
    c0 = cyc; n_out = 0; n_done = 0;
    num_vec = 8'd0; start = 1'b1;
    push_job(c0, 0, 1000);
    @(posedge clk); #1; start = 1'b0;
    wait_until(c0 + 8);
    check("B_done_cycle", last_done_cyc - c0, 4);
    check("B_n_out", n_out, 0);
    check_empty("B");

    // Abort in cycle 6 of an N=3 job
    c0 = cyc; n_out = 0; n_done = 0;
    num_vec = 8'd3; start = 1'b1;
    push_job(c0, 3, 6);
    @(posedge clk); #1; start = 1'b0;
    wait_until(c0 + 6);
    abort = 1'b1;
    wait_until(c0 + 7);
    abort = 1'b0;
    @(negedge clk);
    check("C_outs_zero", int'(all_out), 0);
    check("C_busy", int'(busy), 0);
    @(posedge clk); #1;
    wait_until(c0 + 14);
    check("C_no_done", n_done, 0);
    check_empty("C");
    c0 = cyc; n_done = 0;
    num_vec = 8'd2; start = 1'b1;
    push_job(c0, 2, 1000);
    @(posedge clk); #1; start = 1'b0;
    wait_until(c0 + 13);
    check("C2_done_cycle", last_done_cyc - c0, 10);
    check("C2_n_done", n_done, 1);
    check_empty("C2");

    // start held high: second job only after IDLE sampling
    c0 = cyc; n_done = 0;
    num_vec = 8'd3; start = 1'b1;
    push_job(c0, 3, 1000);
    push_job(c0 + 12, 3, 1000);
    wait_until(c0 + 13);
    start = 1'b0;
    wait_until(c0 + 12 + 14);
    check("D_n_done", n_done, 2);
    check("D_last_done_cycle", last_done_cyc - c0, 23);
    check_empty("D");

    // Asynchronous reset in DRAIN
    c0 = cyc; n_out = 0; n_done = 0;
    num_vec = 8'd3; start = 1'b1;
    push_job(c0, 3, 8);
    @(posedge clk); #1; start = 1'b0;
    wait_until(c0 + 9);
    #2 rst_n = 1'b0;
    #1;
    check("E_async_clear", int'(all_out), 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    wait_until(cyc + 20);
    check("E_n_out", n_out, 1);
    check("E_no_done", n_done, 0);
    check("E_idle_busy", int'(busy), 0);
    check_empty("E");

    // Full-range job, N=255
    c0 = cyc; n_out = 0; n_done = 0; last_addr = -1;
    num_vec = 8'd255; start = 1'b1;
    push_job(c0, 255, 100000);
    @(posedge clk); #1; start = 1'b0;
    wait_until(c0 + 268);
    check("F_n_out", n_out, 255);
    check("F_last_addr", last_addr, 254);
    check("F_n_done", n_done, 1);
    check("F_done_cycle", last_done_cyc - c0, 263);
    check_empty("F");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sys_array_ctrl.md
SYS_ARRAY_CTRL -- requirements
Module: sys_array_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 2, giving the number of systolic rows in the array.
REQ-002 The block SHALL have parameter COLS, default 2, giving the number of PEs per row (row_width).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the vector count and index fields.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begin a job; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous job cancel.
REQ-008 The block SHALL have port num_vec, input, CNT_W bits: input vectors per job (N), captured when start is accepted.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-011 The block SHALL have port w_rd_en, output, 1 bit: weight buffer read strobe.
REQ-012 The block SHALL have port w_rd_addr, output, clog2(ROWS) bits (min 1): weight row address.
REQ-013 The block SHALL have port w_shift, output, 1 bit: shifts weights one row down the w_in/w_out chain.
REQ-014 The block SHALL have port weight_wren, output, ROWS bits: one bit per row, fanned to all COLS weight-write lanes of that row.
REQ-015 The block SHALL have port row_active, output, ROWS bits: active input of each row, skewed.
REQ-016 The block SHALL have port vec_idx, output, CNT_W bits: activation index presented to row 0.
REQ-017 The block SHALL have port out_wr_en, output, 1 bit: result write strobe.
REQ-018 The block SHALL have port out_addr, output, CNT_W bits: result index.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD_W, LATCH_W, STREAM, DRAIN and DONE; a stream-relative counter s SHALL be 0 on the first STREAM cycle.
REQ-020 IDLE SHALL go to LOAD_W on the cycle after start=1 and SHALL capture N=num_vec; start in any other state SHALL be ignored.
REQ-021 LOAD_W SHALL last ROWS cycles with w_rd_en=1, w_shift=1 and w_rd_addr counting ROWS-1 down to 0.
REQ-022 LATCH_W SHALL last 1 cycle with weight_wren all ones; weight_wren SHALL be 0 in every other state.
REQ-023 If N=0, LATCH_W SHALL go directly to DONE with no row_active or out_wr_en activity.
REQ-024 STREAM SHALL last N+ROWS-1 cycles.
REQ-025 row_active[r] SHALL be high exactly for s in r..r+N-1.
REQ-026 vec_idx SHALL equal s while s<N and SHALL hold 0 otherwise.
REQ-027 Result latency L=ROWS+COLS: out_wr_en SHALL be high for s in L..L+N-1 with out_addr=s-L, and 0 otherwise.
REQ-028 DRAIN SHALL follow STREAM and SHALL last COLS+1 cycles, ending on the last out_wr_en cycle.
REQ-029 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE.
REQ-030 The s counter SHALL be CNT_W+clog2(ROWS+COLS)+1 bits so that N=2^CNT_W-1 does not wrap.
REQ-031 When abort=1 in any state other than IDLE, the block SHALL enter IDLE on the next edge, clear all strobes and counters, and not pulse done; abort SHALL override start.

Reset
REQ-032 When rst_n=0, the block SHALL enter IDLE immediately.
REQ-033 When rst_n=0, all outputs SHALL be 0, including busy, done, w_rd_en, w_rd_addr, w_shift, weight_wren, row_active, vec_idx, out_wr_en and out_addr.
REQ-034 Reset mid-job SHALL discard the job; after release the block SHALL wait for a new start.

Verification
REQ-035 With ROWS=2, COLS=2, N=3 and start at cycle 0: the bench SHALL check LOAD_W in cycles 1-2 (w_rd_addr 1,0), weight_wren=2'b11 in cycle 3, row_active[0] in 4-6, row_active[1] in 5-7, out_wr_en in 8-10 (out_addr 0,1,2), and done in cycle 11.
REQ-036 With N=0: the bench SHALL check weight_wren in cycle 3, done in cycle 4, and no row_active or out_wr_en activity.
REQ-037 With abort=1 in cycle 6 of the REQ-035 job: the bench SHALL check that from cycle 7 all outputs are 0, busy=0, done is never asserted, and a new start is accepted.
REQ-038 With start held high through a job: the bench SHALL check that exactly one job runs and that a second job begins only when start is sampled in IDLE after DONE.
REQ-039 With rst_n pulsed low asynchronously during DRAIN: the bench SHALL check that outputs clear without waiting for a clock edge and that out_wr_en does not reassert after release.
REQ-040 With N=255 and CNT_W=8: the bench SHALL check 255 out_wr_en pulses with out_addr 0..254, no wrap, and a single done.
